fifo_pkt_reader: RTL
====================

Name: fifo_pkt_reader

Overview:
- Drain side of the switch port FIFO.
- Pops bytes from one 8-bit FIFO through its empty/read interface, parses the packet framing and checks parity.
- Presents the bytes on an output port with a valid/ready handshake, tagging start of packet, end of packet and parity error.
- Sits between each output FIFO and the port pins. The write side of the FIFO is fed by the switch router logic.

Parameters:
- DATA_W, 8, FIFO and port byte width; only 8 is supported.
- BUF_DEPTH, 2, output holding buffer entries; only 2 is supported.

Ports:
- clk  in  1  single clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  8  FIFO read data; valid in the cycle after fifo_read is sampled high
- fifo_read  out  1  FIFO pop request
- port_ready  in  1  downstream accepts the current byte
- port_vld  out  1  port_data is valid
- port_data  out  8  output byte
- port_sop  out  1  current byte is a header
- port_eop  out  1  current byte is a parity byte
- port_err  out  1  valid only with port_eop; parity mismatch
- busy  out  1  a packet is partially read (state is not HDR)

Behaviour:
- Reset: clk, reset is synchronous active-high. All outputs are 0, the buffer is emptied, the in-flight flag is cleared, state is HDR and the running parity is 0.
- Reset mid-packet: the partial packet is abandoned. A byte returned by the FIFO in the cycle after reset is discarded.
- Packet format:
  - header byte: length L = hdr[7:2] (0..63), address = hdr[1:0]
  - then L payload bytes
  - then one parity byte, equal to the XOR of the header and all payload bytes
- FIFO handshake:
  - inflight is a register, equal to the previous cycle's fifo_read.
  - pop = port_vld & port_ready.
  - fifo_read = ~fifo_empty & (occ + inflight - pop < 2), where occ is the number of valid buffer entries. It is combinational on the registered occ/inflight plus port_ready.
  - A byte arriving from the FIFO is written into the buffer in the arrival cycle. The buffer never overflows.
- Latency: fifo_read high in cycle N gives port_vld high in cycle N+2 when the buffer is empty. Sustained throughput is 1 byte per cycle while port_ready=1 and the FIFO is not empty.
- Parse FSM, advanced on each arriving byte (not on port pops):
  - HDR:
    - capture L into cnt and set parity = byte; tag sop=1.
    - L=0 goes to PAR; otherwise goes to PAY.
  - PAY:
    - parity ^= byte and cnt decrements.
    - When cnt reaches 1 before the decrement, go to PAR.
  - PAR:
    - tag eop=1 and err=(byte != parity).
    - Clear parity and go to HDR.
- Buffer: a 2-entry FIFO ordered as {data, sop, eop, err}. The head drives the port_* outputs.
  - port_data, port_sop, port_eop and port_err are 0 when port_vld=0.
  - Outputs hold stable while port_vld=1 and port_ready=0.
- Simultaneous pop and arrival in the same cycle: occ is unchanged and the order is preserved.
- A FIFO going empty mid-packet stalls parsing without error; the FSM holds its state.
- port_ready is allowed to toggle at any time; no byte is lost or duplicated.

Optional Feature:
- Macro: FIFO_PKT_STATS_EN.
- When defined, adds output pkt_cnt[15:0] and err_cnt[15:0].
  - pkt_cnt increments on every popped eop byte.
  - err_cnt increments on every popped eop byte with err=1.
  - Both wrap 0xFFFF to 0x0000 and are cleared by reset.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- FIFO holds 0x0C,0x11,0x22,0x33,0x0C^0x11^0x22^0x33=0x0C, with port_ready=1:
  - port emits the 5 bytes on consecutive cycles.
  - sop on the 1st byte, eop on the 5th, err=0.
  - First port_vld occurs 2 cycles after the first fifo_read.
- Header 0x01 (L=0, addr 1), parity 0x01: two bytes out, sop then eop. A parity byte of 0x00 instead gives err=1.
- Backpressure: 5-byte packet with port_ready low for 4 cycles at byte 2:
  - fifo_read deasserts once occ+inflight=2.
  - port_data holds 0x11; no loss or duplication.
- FIFO empties after the header: busy=1, no port_vld after the header pops. Refilling resumes the sequence with correct parity.
- Reset asserted mid-payload, then a fresh packet 0x04,0xAA,0xAE:
  - outputs go to 0 the cycle after reset.
  - the new packet parses with sop/eop correct and err=0.
- With FIFO_PKT_STATS_EN: 3 packets, one with a bad parity byte → pkt_cnt=3, err_cnt=1.

Source files
------------

// File: rtl/fifo_pkt_reader.sv
// Drain side of a switch port FIFO: pops bytes, parses header/payload/parity framing
// and presents tagged bytes on a valid/ready port. FIFO_PKT_STATS_EN adds pkt_cnt/err_cnt.
module fifo_pkt_reader #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  input  logic              port_ready,
  output logic              port_vld,
  output logic [DATA_W-1:0] port_data,
  output logic              port_sop,
  output logic              port_eop,
  output logic              port_err,
  output logic              busy
`ifdef FIFO_PKT_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt
`endif
);

  // Port handshake: a byte transfers in every cycle where port_vld and port_ready are
  // both high; while port_vld=1 and port_ready=0 all port_* outputs hold stable, and
  // port_vld never drops without a transfer.

  typedef enum logic [1:0] {HDR, PAY, PAR} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              err;
  } entry_t;

  localparam logic [2:0]        DEPTH_L = 3'(BUF_DEPTH);
  localparam logic [DATA_W-3:0] CNT_ONE = (DATA_W-2)'(1);

  state_t            state;
  logic [DATA_W-3:0] cnt;
  logic [DATA_W-1:0] parity;
  logic              inflight;
  entry_t            mem [BUF_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;

  entry_t     head;
  entry_t     arr;
  logic       push;
  logic       pop;
  logic [2:0] level;

  always_comb begin
    push      = inflight;
    pop       = port_vld & port_ready;
    level     = {1'b0, occ} + {2'b0, inflight};
    // Reads are held off during reset so nothing is popped that would be thrown away.
    fifo_read = ~reset & ~fifo_empty & (level < DEPTH_L + {2'b0, pop});
    arr.data  = fifo_data;
    arr.sop   = (state == HDR);
    arr.eop   = (state == PAR);
    arr.err   = (state == PAR) && (fifo_data != parity);
    head      = mem[rd_ptr];
    port_vld  = (occ != 2'd0);
    port_data = port_vld ? head.data : '0;
    port_sop  = port_vld & head.sop;
    port_eop  = port_vld & head.eop;
    port_err  = port_vld & head.err;
    busy      = (state != HDR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HDR;
      cnt      <= '0;
      parity   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      inflight <= fifo_read;
      occ      <= occ + {1'b0, push} - {1'b0, pop};
      if (pop) rd_ptr <= ~rd_ptr;
      if (push) begin
        mem[wr_ptr] <= arr;
        wr_ptr      <= ~wr_ptr;
        // Parsing advances on arriving bytes, so an empty FIFO simply stalls the FSM.
        case (state)
          HDR: begin
            cnt    <= fifo_data[DATA_W-1:2];
            parity <= fifo_data;
            state  <= (fifo_data[DATA_W-1:2] == '0) ? PAR : PAY;
          end
          PAY: begin
            parity <= parity ^ fifo_data;
            cnt    <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= PAR;
          end
          PAR: begin
            parity <= '0;
            state  <= HDR;
          end
          default: state <= HDR;
        endcase
      end
    end
  end

`ifdef FIFO_PKT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= 16'd0;
      err_cnt <= 16'd0;
    end else if (pop && head.eop) begin
      pkt_cnt <= pkt_cnt + 16'd1;
      if (head.err) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
